// File: rtl/snes_rom_loader_pkg.sv
// Shared types and constants for the SNES ROM loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snes_loader_pkg;

  // Width of the header length field and of the payload byte counter
  localparam int LEN_W = 24;

  // First byte of every frame; anything else in IDLE is line noise
  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  // Frame parser states; DONE and ERR are terminal until reset
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_LEN2,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  // UART receiver bit-phase states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/snes_rom_loader_if.sv
// Word write port from the ROM loader toward the DDR3 memory front end.
// Latency: n/a (signal bundle only).
// Backpressure: a word transfers when wr_valid && wr_ready.
interface snes_rom_loader_if #(
  parameter int ADDR_W = 22
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  // Loader side drives the word, memory side drives ready
  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/snes_rom_loader_uart_rx.sv
// 8N1 UART receiver with 2-FF input synchronizer, one byte strobe per frame.
// Latency: byte_valid/frame_err pulse one cycle after the stop-bit sample.
// Backpressure: none; every received byte is presented for exactly one cycle.
module uart_rx
  import snes_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  logic             rxd_meta;
  logic             rxd_sync;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // Two-flop synchronizer; idle line is high so reset to 1
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // Bit-timing FSM: confirm start at half bit, then sample every full bit
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          bit_cnt <= '0;
          if (!rxd_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (bit_cnt == HALF_BIT) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            // A glitch that is high again at mid-bit is not a start bit
            rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == FULL_BIT) begin
            bit_cnt <= '0;
            shreg   <= {rxd_sync, shreg[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_cnt == FULL_BIT) begin
            bit_cnt    <= '0;
            rx_state   <= RX_IDLE;
            byte_data  <= shreg;
            byte_valid <= rxd_sync;
            frame_err  <= !rxd_sync;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/snes_rom_loader.sv
// Parses a framed ROM image from the UART and streams 16-bit words to memory.
// Latency: wr_valid rises one cycle after the byte strobe that completes a word.
// Backpressure: one-word output register; a second word while it is still held is an overrun error.
module snes_rom_loader
  import snes_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 22
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  uart_rxd,
  snes_rom_loader_if.master     wr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_W-1:0]      rom_bytes
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              frame_err;

  loader_state_t     state;
  logic [LEN_W-1:0]  byte_cnt;
  logic [7:0]        csum;
  logic [7:0]        lo_byte;

  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;

  logic              data_byte;
  logic              last_byte;
  logic              word_emit;
  logic [15:0]       word_dat;
  logic              accept;
  logic              overrun;
  logic              ferr_live;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .rxd        (uart_rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;

  // Payload byte classification, word packing and overrun detection
  always_comb begin
    data_byte = (state == ST_DATA) && byte_valid;
    last_byte = data_byte && (byte_cnt == rom_bytes - LEN_W'(1));
    // Odd index closes a pair; a trailing even byte is flushed with a zero high half
    word_emit = data_byte && (byte_cnt[0] || last_byte);
    word_dat  = byte_cnt[0] ? {byte_data, lo_byte} : {8'h00, byte_data};
    accept    = wr_valid_q && wr.wr_ready;
    overrun   = word_emit && wr_valid_q && !wr.wr_ready;
    // Framing errors only matter once a frame has started and before it ends
    ferr_live = frame_err && (state inside {ST_LEN0, ST_LEN1, ST_LEN2, ST_DATA, ST_CSUM});
  end

  // One-deep write register; the address always names the word being offered
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      if (word_emit && !overrun) begin
        wr_valid_q <= 1'b1;
        wr_data_q  <= word_dat;
      end else if (accept) begin
        wr_valid_q <= 1'b0;
      end
      if (accept) wr_addr_q <= wr_addr_q + ADDR_W'(1);
    end
  end

  // Frame parser: magic, 3-byte length, payload, checksum
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      csum      <= '0;
      lo_byte   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rom_bytes <= '0;
    end else if (ferr_live) begin
      state <= ST_ERR;
      busy  <= 1'b0;
      err   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (byte_valid && byte_data == LOADER_MAGIC) begin
            state     <= ST_LEN0;
            busy      <= 1'b1;
            rom_bytes <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
          end
        end
        ST_LEN0: begin
          if (byte_valid) begin
            rom_bytes[7:0] <= byte_data;
            state          <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (byte_valid) begin
            rom_bytes[15:8] <= byte_data;
            state           <= ST_LEN2;
          end
        end
        ST_LEN2: begin
          if (byte_valid) begin
            rom_bytes[23:16] <= byte_data;
            // Empty image skips straight to a checksum of zero
            state <= ({byte_data, rom_bytes[15:0]} != '0) ? ST_DATA : ST_CSUM;
          end
        end
        ST_DATA: begin
          if (data_byte) begin
            csum     <= csum ^ byte_data;
            byte_cnt <= byte_cnt + LEN_W'(1);
            if (!byte_cnt[0]) lo_byte <= byte_data;
            if (overrun) begin
              state <= ST_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else if (last_byte) begin
              state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (byte_valid) begin
            busy <= 1'b0;
            if (byte_data == csum) begin
              state <= ST_DONE;
              // Completion also needs the final word to have left the register
              done  <= !wr_valid_q || wr.wr_ready;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!wr_valid_q || wr.wr_ready) done <= 1'b1;
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
